// File: rtl/axi_pkg.sv
// Shared AXI definitions for the memory-model responder:
//   - burst and response encodings
//   - FSM state types for the write and read channels
//   - next_addr(): beat-to-beat address step for FIXED / INCR / WRAP bursts
package axi_pkg;

   localparam logic [1:0] BURST_FIXED = 2'b00;
   localparam logic [1:0] BURST_INCR  = 2'b01;
   localparam logic [1:0] BURST_WRAP  = 2'b10;
   localparam logic [1:0] BURST_RSVD  = 2'b11;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_EXOKAY = 2'b01;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
   typedef enum logic       {R_IDLE, R_DATA}         r_state_e;

   // Address of the beat following addr. WRAP keeps the bits above the
   // wrap block and steps only the bits inside it; the reserved encoding
   // steps like INCR (the burst is flagged as an error elsewhere).
   function automatic logic [63:0] next_addr(input logic [63:0] addr,
                                             input logic [2:0]  size,
                                             input logic [15:0] len,
                                             input logic [1:0]  burst);
      logic [63:0] step;
      logic [63:0] mask;
      step = 64'd1 << size;
      mask = ((64'(len) + 64'd1) << size) - 64'd1;
      case (burst)
         BURST_FIXED: next_addr = addr;
         BURST_WRAP:  next_addr = (addr & ~mask) | ((addr + step) & mask);
         default:     next_addr = addr + step;
      endcase
   endfunction

endpackage

// File: rtl/axi_burst_addr.sv
// Burst address tracker for one AXI channel.
//   load/start_*  : capture a new burst (address-channel handshake)
//   adv           : step to the next beat (data-channel handshake)
//   idx/in_range/err/last            : current beat (registered state)
//   idx_nxt/in_range_nxt/err_nxt/last_nxt : beat that will be current next
//     cycle, so the read side can fetch its data one cycle ahead.
module axi_burst_addr
   import axi_pkg::*;
#(
   parameter int          ASIZE     = 32,
   parameter int          LSIZE     = 8,
   parameter int          DSIZE     = 32,
   parameter int          DEPTH     = 1024,
   parameter logic [63:0] BASE_ADDR = 64'h0,
   localparam int         SHIFT     = $clog2(DSIZE / 8),
   localparam int         IW        = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic             adv,
   input  logic [ASIZE-1:0] start_addr,
   input  logic [2:0]       start_size,
   input  logic [LSIZE-1:0] start_len,
   input  logic [1:0]       start_burst,
   output logic [IW-1:0]    idx,
   output logic [IW-1:0]    idx_nxt,
   output logic             in_range,
   output logic             in_range_nxt,
   output logic             err,
   output logic             err_nxt,
   output logic             last,
   output logic             last_nxt
);

   localparam logic [63:0] LIMIT = 64'(DEPTH) * 64'(DSIZE / 8);

   logic [ASIZE-1:0] addr_q, addr_d;
   logic [2:0]       size_q, size_d;
   logic [LSIZE-1:0] len_q, len_d;
   logic [1:0]       burst_q, burst_d;
   logic [LSIZE-1:0] beat_q, beat_d;
   logic [63:0]      nxt;
   logic [15:0]      len16;

   function automatic logic [63:0] ext(input logic [ASIZE-1:0] a);
      ext = '0;
      ext[ASIZE-1:0] = a;
   endfunction

   function automatic logic range_ok(input logic [ASIZE-1:0] a);
      logic [63:0] a64;
      a64 = ext(a);
      return (a64 >= BASE_ADDR) && ((a64 - BASE_ADDR) < LIMIT);
   endfunction

   function automatic logic [IW-1:0] word_idx(input logic [ASIZE-1:0] a);
      logic [63:0] off;
      off = (ext(a) - BASE_ADDR) >> SHIFT;
      return off[IW-1:0];
   endfunction

   // Reserved burst, beat wider than the bus, or WRAP with an illegal length.
   function automatic logic burst_err(input logic [2:0]       s,
                                      input logic [LSIZE-1:0] l,
                                      input logic [1:0]       b);
      logic [15:0] l16;
      l16 = '0;
      l16[LSIZE-1:0] = l;
      return (b == BURST_RSVD) || (s > 3'(SHIFT)) ||
             ((b == BURST_WRAP) && !(l16 inside {16'd1, 16'd3, 16'd7, 16'd15}));
   endfunction

   always_comb begin
      addr_d  = addr_q;
      size_d  = size_q;
      len_d   = len_q;
      burst_d = burst_q;
      beat_d  = beat_q;
      len16   = '0;
      len16[LSIZE-1:0] = len_q;
      nxt     = next_addr(ext(addr_q), size_q, len16, burst_q);
      if (load) begin
         addr_d  = start_addr;
         size_d  = start_size;
         len_d   = start_len;
         burst_d = start_burst;
         beat_d  = '0;
      end else if (adv) begin
         addr_d  = nxt[ASIZE-1:0];
         beat_d  = beat_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addr_q  <= '0;
         size_q  <= '0;
         len_q   <= '0;
         burst_q <= '0;
         beat_q  <= '0;
      end else begin
         addr_q  <= addr_d;
         size_q  <= size_d;
         len_q   <= len_d;
         burst_q <= burst_d;
         beat_q  <= beat_d;
      end
   end

   assign idx          = word_idx(addr_q);
   assign idx_nxt      = word_idx(addr_d);
   assign in_range     = range_ok(addr_q);
   assign in_range_nxt = range_ok(addr_d);
   assign err          = burst_err(size_q, len_q, burst_q);
   assign err_nxt      = burst_err(size_d, len_d, burst_d);
   assign last         = (beat_q == len_q);
   assign last_nxt     = (beat_d == len_d);

endmodule

// File: rtl/axi_slave_mem.sv
// AXI4 memory-model responder: byte-strobed word RAM behind independent
// write (AW/W/B) and read (AR/R) channels, one burst in flight per channel.
// Ports follow the AXI4 slave view: AW/W/B write path, AR/R read path,
// lock/cache/prot/qos accepted and ignored. All outputs are registered.
module axi_slave_mem
   import axi_pkg::*;
#(
   parameter int          IDSIZE    = 4,
   parameter int          ASIZE     = 32,
   parameter int          LSIZE     = 8,
   parameter int          DSIZE     = 32,
   parameter int          STSIZE    = DSIZE / 8,
   parameter int          DEPTH     = 1024,
   parameter logic [63:0] BASE_ADDR = 64'h0
) (
   input  logic              axi_aclk,
   input  logic              axi_resetn,
   input  logic [IDSIZE-1:0] axi_awid,
   input  logic [ASIZE-1:0]  axi_awaddr,
   input  logic [LSIZE-1:0]  axi_awlen,
   input  logic [2:0]        axi_awsize,
   input  logic [1:0]        axi_awburst,
   input  logic              axi_awlock,
   input  logic [3:0]        axi_awcache,
   input  logic [2:0]        axi_awprot,
   input  logic [3:0]        axi_awqos,
   input  logic              axi_awvalid,
   output logic              axi_awready,
   input  logic [DSIZE-1:0]  axi_wdata,
   input  logic [STSIZE-1:0] axi_wstrb,
   input  logic              axi_wlast,
   input  logic              axi_wvalid,
   output logic              axi_wready,
   output logic [IDSIZE-1:0] axi_bid,
   output logic [1:0]        axi_bresp,
   output logic              axi_bvalid,
   input  logic              axi_bready,
   input  logic [IDSIZE-1:0] axi_arid,
   input  logic [ASIZE-1:0]  axi_araddr,
   input  logic [LSIZE-1:0]  axi_arlen,
   input  logic [2:0]        axi_arsize,
   input  logic [1:0]        axi_arburst,
   input  logic              axi_arlock,
   input  logic [3:0]        axi_arcache,
   input  logic [2:0]        axi_arprot,
   input  logic [3:0]        axi_arqos,
   input  logic              axi_arvalid,
   output logic              axi_arready,
   output logic [IDSIZE-1:0] axi_rid,
   output logic [DSIZE-1:0]  axi_rdata,
   output logic [1:0]        axi_rresp,
   output logic              axi_rlast,
   output logic              axi_rvalid,
   input  logic              axi_rready
);

   localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [DSIZE-1:0] mem [DEPTH];

   w_state_e          w_state_q, w_state_d;
   r_state_e          r_state_q, r_state_d;
   logic              awready_q, awready_d, wready_q, wready_d, bvalid_q, bvalid_d;
   logic [IDSIZE-1:0] bid_q, bid_d;
   logic [1:0]        bresp_q, bresp_d;
   logic              dec_q, dec_d, slv_q, slv_d;   // sticky per-burst error flags
   logic              arready_q, arready_d, rvalid_q, rvalid_d, rlast_q, rlast_d;
   logic [IDSIZE-1:0] rid_q, rid_d;
   logic [DSIZE-1:0]  rdata_q, rdata_d;
   logic [1:0]        rresp_q, rresp_d;

   logic          w_load, w_adv, w_in_range, w_err, w_last, mem_we;
   logic [IW-1:0] w_idx;
   logic          r_load, r_adv, r_fetch, r_in_range_nxt, r_err_nxt, r_last_nxt;
   logic [IW-1:0] r_idx_nxt;
   logic [IW-1:0] unused_w_idx, unused_r_idx;
   logic          unused_w_flags, unused_r_flags;
   logic [3:0]    unused_wf, unused_rf;
   logic          unused_ok;

   assign unused_ok = ^{axi_awlock, axi_awcache, axi_awprot, axi_awqos,
                        axi_arlock, axi_arcache, axi_arprot, axi_arqos,
                        unused_w_idx, unused_r_idx, unused_wf, unused_rf};
   assign unused_w_flags = ^unused_wf;
   assign unused_r_flags = ^unused_rf;

   // Handshakes qualified by the registered readies so nothing is taken
   // during the cycle right after reset release.
   assign w_load = (w_state_q == W_IDLE) && axi_awvalid && awready_q;
   assign w_adv  = (w_state_q == W_DATA) && axi_wvalid && wready_q;
   assign r_load = (r_state_q == R_IDLE) && axi_arvalid && arready_q;
   assign r_adv  = (r_state_q == R_DATA) && rvalid_q && axi_rready && !rlast_q;

   axi_burst_addr #(.ASIZE(ASIZE), .LSIZE(LSIZE), .DSIZE(DSIZE), .DEPTH(DEPTH),
                    .BASE_ADDR(BASE_ADDR)) u_wr_addr (
      .clk(axi_aclk), .rst_n(axi_resetn), .load(w_load), .adv(w_adv),
      .start_addr(axi_awaddr), .start_size(axi_awsize), .start_len(axi_awlen),
      .start_burst(axi_awburst),
      .idx(w_idx), .idx_nxt(unused_w_idx),
      .in_range(w_in_range), .in_range_nxt(unused_wf[0]),
      .err(w_err), .err_nxt(unused_wf[1]),
      .last(w_last), .last_nxt(unused_wf[2]));
   assign unused_wf[3] = 1'b0;

   axi_burst_addr #(.ASIZE(ASIZE), .LSIZE(LSIZE), .DSIZE(DSIZE), .DEPTH(DEPTH),
                    .BASE_ADDR(BASE_ADDR)) u_rd_addr (
      .clk(axi_aclk), .rst_n(axi_resetn), .load(r_load), .adv(r_adv),
      .start_addr(axi_araddr), .start_size(axi_arsize), .start_len(axi_arlen),
      .start_burst(axi_arburst),
      .idx(unused_r_idx), .idx_nxt(r_idx_nxt),
      .in_range(unused_rf[0]), .in_range_nxt(r_in_range_nxt),
      .err(unused_rf[1]), .err_nxt(r_err_nxt),
      .last(unused_rf[2]), .last_nxt(r_last_nxt));
   assign unused_rf[3] = unused_w_flags;

   // ---------------- write channel ----------------
   always_comb begin
      w_state_d = w_state_q;
      bid_d     = bid_q;
      bresp_d   = bresp_q;
      dec_d     = dec_q;
      slv_d     = slv_q;
      mem_we    = 1'b0;
      case (w_state_q)
         W_IDLE: if (w_load) begin
            bid_d     = axi_awid;
            dec_d     = 1'b0;
            slv_d     = 1'b0;
            w_state_d = W_DATA;
         end
         W_DATA: if (w_adv) begin
            mem_we = w_in_range;
            dec_d  = dec_q | ~w_in_range;
            slv_d  = slv_q | w_err | (axi_wlast != w_last);
            if (axi_wlast || w_last) begin
               w_state_d = W_RESP;
               bresp_d   = dec_d ? RESP_DECERR : (slv_d ? RESP_SLVERR : RESP_OKAY);
            end
         end
         W_RESP: if (axi_bready && bvalid_q) w_state_d = W_IDLE;
         default: w_state_d = W_IDLE;
      endcase
      awready_d = (w_state_d == W_IDLE);
      wready_d  = (w_state_d == W_DATA);
      bvalid_d  = (w_state_d == W_RESP);
   end

   // ---------------- read channel ----------------
   // Data for a beat is fetched when it becomes current (AR handshake or the
   // previous R handshake), so R runs without bubbles. The RAM is read before
   // the same-cycle write lands, giving pre-write data on a collision.
   always_comb begin
      r_state_d = r_state_q;
      rid_d     = rid_q;
      rdata_d   = rdata_q;
      rresp_d   = rresp_q;
      rlast_d   = rlast_q;
      r_fetch   = 1'b0;
      case (r_state_q)
         R_IDLE: if (r_load) begin
            rid_d     = axi_arid;
            r_fetch   = 1'b1;
            r_state_d = R_DATA;
         end
         R_DATA: if (rvalid_q && axi_rready) begin
            if (rlast_q) begin
               rlast_d   = 1'b0;
               r_state_d = R_IDLE;
            end else begin
               r_fetch = 1'b1;
            end
         end
         default: r_state_d = R_IDLE;
      endcase
      if (r_fetch) begin
         rdata_d = r_in_range_nxt ? mem[r_idx_nxt] : '0;
         rresp_d = !r_in_range_nxt ? RESP_DECERR : (r_err_nxt ? RESP_SLVERR : RESP_OKAY);
         rlast_d = r_last_nxt;
      end
      arready_d = (r_state_d == R_IDLE);
      rvalid_d  = (r_state_d == R_DATA);
   end

   always_ff @(posedge axi_aclk or negedge axi_resetn) begin
      if (!axi_resetn) begin
         w_state_q <= W_IDLE;
         awready_q <= 1'b0;
         wready_q  <= 1'b0;
         bvalid_q  <= 1'b0;
         bid_q     <= '0;
         bresp_q   <= '0;
         dec_q     <= 1'b0;
         slv_q     <= 1'b0;
         r_state_q <= R_IDLE;
         arready_q <= 1'b0;
         rvalid_q  <= 1'b0;
         rlast_q   <= 1'b0;
         rid_q     <= '0;
         rdata_q   <= '0;
         rresp_q   <= '0;
      end else begin
         w_state_q <= w_state_d;
         awready_q <= awready_d;
         wready_q  <= wready_d;
         bvalid_q  <= bvalid_d;
         bid_q     <= bid_d;
         bresp_q   <= bresp_d;
         dec_q     <= dec_d;
         slv_q     <= slv_d;
         r_state_q <= r_state_d;
         arready_q <= arready_d;
         rvalid_q  <= rvalid_d;
         rlast_q   <= rlast_d;
         rid_q     <= rid_d;
         rdata_q   <= rdata_d;
         rresp_q   <= rresp_d;
      end
   end

   // RAM contents are deliberately not reset.
   always_ff @(posedge axi_aclk) begin
      if (mem_we) begin
         for (int b = 0; b < STSIZE; b++)
            if (axi_wstrb[b]) mem[w_idx][8*b +: 8] <= axi_wdata[8*b +: 8];
      end
   end

   assign axi_awready = awready_q;
   assign axi_wready  = wready_q;
   assign axi_bvalid  = bvalid_q;
   assign axi_bid     = bid_q;
   assign axi_bresp   = bresp_q;
   assign axi_arready = arready_q;
   assign axi_rvalid  = rvalid_q;
   assign axi_rlast   = rlast_q;
   assign axi_rid     = rid_q;
   assign axi_rdata   = rdata_q;
   assign axi_rresp   = rresp_q;

endmodule

// File: tb/tb_axi_slave_mem.sv
// Directed bench for axi_slave_mem: inputs driven on the falling edge,
// outputs sampled on the falling edge, handshakes on the rising edge.
module tb_axi_slave_mem;
   import axi_pkg::*;

   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic [3:0]  awid = '0, bid, arid = '0, rid;
   logic [31:0] awaddr = '0, araddr = '0, wdata = '0, rdata;
   logic [7:0]  awlen = '0, arlen = '0;
   logic [2:0]  awsize = '0, arsize = '0;
   logic [1:0]  awburst = '0, arburst = '0, bresp, rresp;
   logic [3:0]  wstrb = '0;
   logic        awvalid = 0, awready, wlast = 0, wvalid = 0, wready, bvalid, bready = 0;
   logic        arvalid = 0, arready, rlast, rvalid, rready = 0;

   int n_tests = 0;
   int n_fail  = 0;

   logic [31:0] wd [16];
   logic [31:0] rx [16];
   logic [1:0]  rr [16];

   always #5 clk = ~clk;

   axi_slave_mem dut (
      .axi_aclk(clk), .axi_resetn(resetn),
      .axi_awid(awid), .axi_awaddr(awaddr), .axi_awlen(awlen), .axi_awsize(awsize),
      .axi_awburst(awburst), .axi_awlock(1'b0), .axi_awcache(4'h0), .axi_awprot(3'h0),
      .axi_awqos(4'h0), .axi_awvalid(awvalid), .axi_awready(awready),
      .axi_wdata(wdata), .axi_wstrb(wstrb), .axi_wlast(wlast), .axi_wvalid(wvalid),
      .axi_wready(wready), .axi_bid(bid), .axi_bresp(bresp), .axi_bvalid(bvalid),
      .axi_bready(bready),
      .axi_arid(arid), .axi_araddr(araddr), .axi_arlen(arlen), .axi_arsize(arsize),
      .axi_arburst(arburst), .axi_arlock(1'b0), .axi_arcache(4'h0), .axi_arprot(3'h0),
      .axi_arqos(4'h0), .axi_arvalid(arvalid), .axi_arready(arready),
      .axi_rid(rid), .axi_rdata(rdata), .axi_rresp(rresp), .axi_rlast(rlast),
      .axi_rvalid(rvalid), .axi_rready(rready));

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   // Write burst of nbeats beats from wd[]; wlast on the final beat offered.
   task automatic wr(input string tag, input logic [31:0] addr, input logic [7:0] len,
                     input logic [2:0] sz, input logic [1:0] bst, input logic [3:0] strb,
                     input int nbeats, input int bhold, input logic [1:0] exp_resp,
                     input logic [3:0] id);
      int n;
      @(negedge clk);
      awaddr = addr; awlen = len; awsize = sz; awburst = bst; awid = id; awvalid = 1;
      n = 0;
      while (!awready && n < 20) begin @(negedge clk); n++; end
      chk({tag, "/awready"}, awready, 1);
      @(posedge clk); @(negedge clk);
      awvalid = 0;
      chk({tag, "/wready_next"}, wready, 1);
      for (int i = 0; i < nbeats; i++) begin
         wdata = wd[i]; wstrb = strb; wlast = (i == nbeats - 1); wvalid = 1;
         n = 0;
         while (!wready && n < 20) begin @(negedge clk); n++; end
         @(posedge clk); @(negedge clk);
      end
      wvalid = 0; wlast = 0;
      chk({tag, "/bvalid_next"}, bvalid, 1);
      chk({tag, "/wready_off"}, wready, 0);
      for (int c = 0; c < bhold; c++) begin
         @(negedge clk);
         chk($sformatf("%s/bhold%0d", tag, c), {bvalid, bresp, bid}, {1'b1, exp_resp, id});
      end
      chk({tag, "/bresp"}, bresp, exp_resp);
      chk({tag, "/bid"}, bid, id);
      bready = 1;
      @(posedge clk); @(negedge clk);
      bready = 0;
      chk({tag, "/bvalid_clr"}, bvalid, 0);
   endtask

   // Read burst; rready follows rpat bit per cycle; expects rx[]/rr[].
   task automatic rd(input string tag, input logic [31:0] addr, input logic [7:0] len,
                     input logic [2:0] sz, input logic [1:0] bst, input logic [3:0] id,
                     input logic [15:0] rpat);
      int n, beat, cyc;
      @(negedge clk);
      araddr = addr; arlen = len; arsize = sz; arburst = bst; arid = id; arvalid = 1;
      n = 0;
      while (!arready && n < 20) begin @(negedge clk); n++; end
      chk({tag, "/arready"}, arready, 1);
      @(posedge clk); @(negedge clk);
      arvalid = 0;
      beat = 0; cyc = 0;
      while (beat <= int'(len) && cyc < 64) begin
         rready = rpat[cyc % 16];
         if (rvalid) begin
            chk($sformatf("%s/b%0d", tag, beat), {rdata, rresp, rlast, rid},
                {rx[beat], rr[beat], 1'(beat == int'(len)), id});
            if (rready) beat++;
         end else begin
            chk($sformatf("%s/rvalid%0d", tag, beat), rvalid, 1);
         end
         @(posedge clk); @(negedge clk);
         cyc++;
      end
      rready = 0;
      chk({tag, "/beats"}, beat, int'(len) + 1);
      chk({tag, "/idle"}, {rvalid, arready}, 2'b01);
   endtask

   initial begin
      // Reset state
      #3;
      chk("rst/outs", {awready, wready, bvalid, arready, rvalid, rlast}, 6'b0);
      chk("rst/payload", {bid, bresp, rid, rresp, rdata}, '0);
      @(negedge clk); @(negedge clk);
      resetn = 1;
      @(posedge clk); #1;
      chk("rst/readies", {awready, arready}, 2'b11);

      // INCR write then read back
      wd[0] = 32'hA0; wd[1] = 32'hA1; wd[2] = 32'hA2; wd[3] = 32'hA3;
      wr("incr_wr", 32'h10, 3, 2, BURST_INCR, 4'hF, 4, 0, RESP_OKAY, 4'd5);
      for (int i = 0; i < 4; i++) begin rx[i] = 32'hA0 + i; rr[i] = RESP_OKAY; end
      rd("incr_rd", 32'h10, 3, 2, BURST_INCR, 4'd5, 16'hFFFF);

      // Byte strobes
      wd[0] = 32'h12345678;
      wr("w40", 32'h40, 0, 2, BURST_INCR, 4'hF, 1, 0, RESP_OKAY, 4'd1);
      wd[0] = 32'hFFFFFFFF;
      wr("strb", 32'h40, 0, 2, BURST_INCR, 4'b0101, 1, 0, RESP_OKAY, 4'd1);
      rx[0] = 32'h12FF56FF; rr[0] = RESP_OKAY;
      rd("strb_rd", 32'h40, 0, 2, BURST_INCR, 4'd2, 16'hFFFF);

      // WRAP read: 0x18, 0x1C, 0x10, 0x14
      rx[0] = 32'hA2; rx[1] = 32'hA3; rx[2] = 32'hA0; rx[3] = 32'hA1;
      for (int i = 0; i < 4; i++) rr[i] = RESP_OKAY;
      rd("wrap_rd", 32'h18, 3, 2, BURST_WRAP, 4'd3, 16'hFFFF);

      // FIXED write: both beats hit the same word
      wd[0] = 32'h11; wd[1] = 32'h22;
      wr("fixed_wr", 32'h50, 1, 2, BURST_FIXED, 4'hF, 2, 0, RESP_OKAY, 4'd4);
      rx[0] = 32'h22; rr[0] = RESP_OKAY;
      rd("fixed_rd", 32'h50, 0, 2, BURST_INCR, 4'd4, 16'hFFFF);

      // Top-of-memory boundary; word 0 must not be hit by the out-of-range beat
      wd[0] = 32'h0BADF00D;
      wr("w0", 32'h0, 0, 2, BURST_INCR, 4'hF, 1, 0, RESP_OKAY, 4'd6);
      wd[0] = 32'h55AA55AA; wd[1] = 32'h99999999;
      wr("edge_wr", 32'hFFC, 1, 2, BURST_INCR, 4'hF, 2, 0, RESP_DECERR, 4'd7);
      rx[0] = 32'h55AA55AA; rr[0] = RESP_OKAY; rx[1] = 32'h0; rr[1] = RESP_DECERR;
      rd("edge_rd", 32'hFFC, 1, 2, BURST_INCR, 4'd7, 16'hFFFF);
      rx[0] = 32'h0BADF00D; rr[0] = RESP_OKAY;
      rd("w0_rd", 32'h0, 0, 2, BURST_INCR, 4'd6, 16'hFFFF);

      // Backpressure: rready 1,0,0,1,... and bready held low 5 cycles
      for (int i = 0; i < 4; i++) begin rx[i] = 32'hA0 + i; rr[i] = RESP_OKAY; end
      rd("bp_rd", 32'h10, 3, 2, BURST_INCR, 4'd9, 16'hFFF9);
      wd[0] = 32'hC0; wd[1] = 32'hC1;
      wr("bhold_wr", 32'h20, 1, 2, BURST_INCR, 4'hF, 2, 5, RESP_OKAY, 4'd8);

      // Error responses
      wd[0] = 32'h1;
      wr("rsvd_wr", 32'h30, 0, 2, BURST_RSVD, 4'hF, 1, 0, RESP_SLVERR, 4'd2);
      wd[0] = 32'h2; wd[1] = 32'h3;
      wr("early_wr", 32'h30, 3, 2, BURST_INCR, 4'hF, 2, 0, RESP_SLVERR, 4'd3);
      rx[0] = 32'hA0; rr[0] = RESP_SLVERR;
      rd("size_rd", 32'h10, 0, 3, BURST_INCR, 4'd1, 16'hFFFF);

      // Reset in the middle of a 4-beat write (during beat 2)
      @(negedge clk);
      awaddr = 32'h60; awlen = 3; awsize = 2; awburst = BURST_INCR; awid = 4'd1; awvalid = 1;
      @(posedge clk); @(negedge clk);
      awvalid = 0; wdata = 32'hD0; wstrb = 4'hF; wlast = 0; wvalid = 1;
      @(posedge clk); @(negedge clk);
      wdata = 32'hD1;
      @(posedge clk); @(negedge clk);
      wdata = 32'hD2;
      #1 resetn = 0;
      #1;
      chk("mid_rst/outs", {awready, wready, bvalid, arready, rvalid}, 5'b0);
      wvalid = 0;
      @(negedge clk);
      resetn = 1;
      @(posedge clk); #1;
      chk("mid_rst/awready", awready, 1);
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         chk($sformatf("mid_rst/quiet%0d", c), {bvalid, wready}, 2'b00);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

endmodule
